// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    ADD1,
    ADD2,
    SUB1,
    SUB2
  } booth_op_e;

  // Width of the iteration counter that walks WIDTH/2 radix-4 digits.
  function automatic int cnt_width(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/booth_radix4_enc.sv
// Combinational radix-4 Booth digit encoder: maps a 3-bit multiplier window
// to an operation and the matching sign-extended WIDTH+2-bit partial product.
module booth_radix4_enc
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       window,
  input  logic [WIDTH-1:0] m,
  output booth_op_e        op,
  output logic [WIDTH+1:0] pp
);

  logic [WIDTH+1:0] m1;
  logic [WIDTH+1:0] m2;

  always_comb begin
    op = ZERO;
    pp = '0;
    m1 = {{2{m[WIDTH-1]}}, m};
    m2 = {m[WIDTH-1], m, 1'b0};

    case (window)
      3'b001, 3'b010: op = ADD1;
      3'b011:         op = ADD2;
      3'b100:         op = SUB2;
      3'b101, 3'b110: op = SUB1;
      default:        op = ZERO;
    endcase

    case (op)
      ADD1:    pp = m1;
      ADD2:    pp = m2;
      SUB1:    pp = -m1;
      SUB2:    pp = -m2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth signed multiplier, WIDTH/2 iterations per product.
// Optional overflow flag output is enabled by defining BOOTH_MULT_OVF_EN.
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
`ifdef BOOTH_MULT_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH / 2 - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   mpl_q, mpl_d;
  logic [WIDTH+1:0]   acc_q, acc_d;
  logic               qm1_q, qm1_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH+1:0]   sum;
  logic [WIDTH+1:0]   pp;
  booth_op_e          op;

  booth_radix4_enc #(.WIDTH(WIDTH)) u_enc (
    .window (({mpl_q[1:0], qm1_q})),
    .m      (m_q),
    .op     (op),
    .pp     (pp)
  );

`ifdef BOOTH_MULT_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    mpl_d     = mpl_q;
    acc_d     = acc_q;
    qm1_d     = qm1_q;
    product_d = product_q;
`ifdef BOOTH_MULT_OVF_EN
    ovf_d     = ovf_q;
`endif
    sum       = (op == ZERO) ? acc_q : acc_q + pp;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = a;
          mpl_d   = b;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Arithmetic shift of {acc, multiplier, q(-1)} right by one radix-4 digit.
        acc_d = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
        mpl_d = {sum[1:0], mpl_q[WIDTH-1:2]};
        qm1_d = mpl_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          product_d = {acc_d[WIDTH-1:0], mpl_d};
`ifdef BOOTH_MULT_OVF_EN
          // Fits in WIDTH signed bits only if the top WIDTH+1 bits are all equal.
          ovf_d = ~((&product_d[2*WIDTH-1:WIDTH-1]) | ~(|product_d[2*WIDTH-1:WIDTH-1]));
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      mpl_q     <= '0;
      acc_q     <= '0;
      qm1_q     <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BOOTH_MULT_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      mpl_q     <= mpl_d;
      acc_q     <= acc_d;
      qm1_q     <= qm1_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BOOTH_MULT_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
`ifdef BOOTH_MULT_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier: the driver predicts accepted
// multiplies with integer arithmetic, the monitor checks every DUT cycle.
module tb_booth_seq_multiplier;

  localparam int W      = 32;
  localparam int LAT    = W / 2;     // accept edge -> edge entering DONE
  localparam int PERIOD = W / 2 + 2; // accept edge -> earliest next accept edge

  logic           clk;
  logic           res;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
`ifdef BOOTH_MULT_OVF_EN
  logic           ovf;
`endif

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .res     (res),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
`ifdef BOOTH_MULT_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  typedef struct {
    logic [2*W-1:0] prod;
    logic           ovf;
    int             due;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  int             edge_idx = 0;
  int             last_accept = 0;
  bit             acc_valid = 0;
  int             free_edge = 0;
  logic [2*W-1:0] held_exp = '0;
  logic           held_ovf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int due);
    longint p;
    longint lim;
    exp_t   e;
    p      = longint'($signed(x)) * longint'($signed(y));
    lim    = longint'(1) <<< (W - 1);
    e.prod = 64'(p);
    e.ovf  = (p >= lim) || (p < -lim);
    e.due  = due;
    return e;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (edge %0d)", name, got, want, edge_idx);
    end
  endtask

  // One clock: present inputs, let the edge happen, predict acceptance.
  task automatic step(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
    start = s;
    a     = x;
    b     = y;
    @(posedge clk);
    edge_idx++;
    if (s && res && edge_idx >= free_edge) begin
      sb.push_back(model(x, y, edge_idx + LAT));
      last_accept = edge_idx;
      acc_valid   = 1'b1;
      free_edge   = edge_idx + PERIOD;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom);
  endtask

  task automatic abort_now();
    #2;
    res       = 1'b0;
    sb.delete();
    acc_valid = 1'b0;
    free_edge = 0;
    held_exp  = '0;
    held_ovf  = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_product", product, '0);
`ifdef BOOTH_MULT_OVF_EN
    check("abort_ovf", 64'(ovf), 64'(0));
`endif
    step(1'b1, $urandom, $urandom);
    #2;
    res = 1'b1;
  endtask

  // Monitor: cycle-level busy, done timing, product value and hold.
  initial begin
    exp_t e;
    bit   busy_exp;
    forever begin
      @(negedge clk);
      busy_exp = res && acc_valid && (edge_idx - last_accept <= LAT);
      check("busy", 64'(busy), 64'(busy_exp));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 want done=0 (edge %0d)", edge_idx);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 64'(edge_idx), 64'(e.due));
          check("product", product, e.prod);
`ifdef BOOTH_MULT_OVF_EN
          check("ovf", 64'(ovf), 64'(e.ovf));
`endif
          held_exp = e.prod;
          held_ovf = e.ovf;
        end
      end else begin
        check("product_hold", product, held_exp);
`ifdef BOOTH_MULT_OVF_EN
        check("ovf_hold", 64'(ovf), 64'(held_ovf));
`endif
        if (sb.size() > 0 && edge_idx >= sb[0].due) begin
          checks++;
          errors++;
          $display("FAIL missing_done: got done=%b want done=1 (edge %0d)", done, edge_idx);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] corners[5];
    logic [W-1:0] x;
    logic [W-1:0] y;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;

    start = 1'b0;
    a     = '0;
    b     = '0;
    res   = 1'b1;
    #2;
    res   = 1'b0;
    step(1'b1, 32'd3, 32'd4);
    step(1'b1, 32'd3, 32'd4);
    step(1'b1, 32'd3, 32'd4);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_product", product, '0);
`ifdef BOOTH_MULT_OVF_EN
    check("reset_ovf", 64'(ovf), 64'(0));
`endif
    #2;
    res = 1'b1;
    idle(3);

    // Mixed sign and extremes.
    step(1'b1, 32'd7, -32'sd3);
    idle(20);
    step(1'b1, 32'h8000_0000, 32'h8000_0000);
    idle(20);
    step(1'b1, 32'h7FFF_FFFF, 32'd1);
    idle(20);
    step(1'b1, 32'd0, 32'h1234_5678);
    idle(20);

    // Starts during RUN and during DONE must be ignored.
    step(1'b1, 32'd5, 32'd6);
    idle(3);
    step(1'b1, 32'd9, 32'd9);
    idle(12);
    step(1'b1, 32'd9, 32'd9);
    idle(20);

    // Held start: one accept every PERIOD edges.
    for (int i = 0; i < PERIOD + 1; i++) step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(20);

    // Reset in the middle of RUN.
    step(1'b1, 32'd11, 32'd13);
    idle(7);
    abort_now();
    idle(20);

    // Randomized traffic with corner operands and occasional aborts.
    for (int n = 0; n < 150; n++) begin
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      step($urandom_range(0, 3) != 0, x, y);
      if ($urandom_range(0, 19) == 0) abort_now();
      idle($urandom_range(0, 20));
    end

    idle(25);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_seq_multiplier.md
# booth_seq_multiplier

Sequential radix-4 Booth signed multiplier for the datapath multiply unit. Takes two signed WIDTH-bit operands on a start pulse and runs WIDTH/2 iterations, one per cycle. Presents a 2·WIDTH-bit product with a one-cycle `done` strobe. `done` drives the `we` input of the downstream 64-bit product register, and `product` drives its `d` input.

## Interface
- `WIDTH`, 32: operand width. Must be even and ≥4. Product width is 2·WIDTH.
- `clk` in 1: single clock. All state updates on the rising edge.
- `res` in 1: asynchronous, active-low reset.
- `start` in 1: request a multiply. Sampled only in IDLE.
- `a` in WIDTH: multiplicand, signed two's complement.
- `b` in WIDTH: multiplier, signed two's complement.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle strobe in DONE. Serves as the product register write enable.
- `product` out 2·WIDTH: signed result, held until the next result is written.
- `ovf` out 1: result does not fit in WIDTH signed bits. Valid with `done`. Present only with the macro (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when `start`=1. Capture `a` into M and `b` into the multiplier field. Clear the accumulator and the appended LSB q(-1). Set iteration counter to 0.
  - RUN holds for WIDTH/2 cycles. Counter increments each cycle. After the iteration with counter = WIDTH/2−1, go to DONE.
  - DONE→IDLE unconditionally after one cycle.
- Each RUN iteration:
  - Booth-encode the window {b[1], b[0], q(-1)}:
    - 000 or 111: 0
    - 001 or 010: +M
    - 011: +2M
    - 100: −2M
    - 101 or 110: −M
  - Add the selected partial product to the upper accumulator half. Use WIDTH+2 bits, with M sign-extended.
  - Arithmetic-shift {acc, b, q(-1)} right by 2.
- On the RUN→DONE edge, write `product` from the concatenated accumulator and multiplier fields. `product` is not updated at any other time.
- `start` in RUN or DONE is ignored. No queueing. Operand changes after capture have no effect.
- Boundary values:
  - −2^(WIDTH−1) × −2^(WIDTH−1) = +2^(2·WIDTH−2). This is exact because the accumulator is WIDTH+2 bits wide.
  - A zero operand gives product 0.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `product` 0, `ovf` 0, counter 0, accumulator 0.
- Latency, with `start` sampled at edge T:
  - RUN occupies cycles T+1 … T+WIDTH/2 (16 cycles for WIDTH=32).
  - `done`=1 in cycle T+WIDTH/2+1 (T+17).
  - IDLE at T+WIDTH/2+2.
- Earliest next `start` is sampled at T+WIDTH/2+2, so sustained throughput is one result per WIDTH/2+2 cycles.
- `product` and `ovf` change only on the edge that enters DONE. They are stable for the whole `done` cycle and afterwards.
- Reset asserted mid-RUN or in DONE:
  - Immediate return to reset values. No `done` is produced.
  - `product` reads 0.
- `done` is registered and glitch-free, so it is safe to use as a register write enable.

## Configuration
- `BOOTH_MULT_OVF_EN` defined:
  - `ovf` port exists.
  - `ovf` = NOT(all bits product[2·WIDTH−1 : WIDTH−1] equal), computed from the final result.
  - `ovf` is registered with `product`.
- `BOOTH_MULT_OVF_EN` undefined:
  - `ovf` port absent.
  - No overflow logic is synthesized.

## Structure
- Package `mult_pkg` holds:
  - FSM state enum {IDLE, RUN, DONE}.
  - Booth operation encoding {ZERO, ADD1, ADD2, SUB1, SUB2}.
  - Function for the counter width, $clog2(WIDTH/2).
- Sub-module `booth_radix4_enc`: combinational. Maps the 3-bit window to the Booth operation encoding, and provides the selected signed WIDTH+2-bit partial product given M.

## Test plan
- Reset: hold `res`=0 for 3 cycles → `busy`=0, `done`=0, `product`=0, `ovf`=0. Release it → still IDLE.
- Mixed sign: a=7, b=−3, `start` at T → `busy` high T+1…T+17. `done` only at T+17, with product=0xFFFF_FFFF_FFFF_FFEB and `ovf`=0.
- Extreme: a=b=0x8000_0000 → product=0x4000_0000_0000_0000 and `ovf`=1. Also a=0x7FFF_FFFF, b=1 → product=0x0000_0000_7FFF_FFFF and `ovf`=0.
- Ignored start: a=5, b=6 at T. Then `start` with a=9, b=9 at T+4 and again at T+17 → single `done` at T+17 with product 30. No second `done`.
- Back-to-back: `start` held high with a=−1, b=−1 → `done` at T+17 and T+35, each with product 1.
- Abort: `res` low at T+8 during RUN → all outputs 0 asynchronously. No `done` appears before the next accepted `start`.
